// File: rtl/kyo_sprite_pkg.sv
// Shared sprite geometry, address width and sequencer state type for the Kyo
// sprite datapath.
package kyo_sprite_pkg;

    localparam int SPRITE_W    = 64;
    localparam int SPRITE_H    = 96;
    localparam int FRAME_WORDS = SPRITE_W * SPRITE_H;
    localparam int ADDR_W      = 17;

    typedef enum logic {
        IDLE = 1'b0,
        KICK = 1'b1
    } anim_state_t;

    // Width of a counter that must reach n-1. It never collapses to zero bits.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/kyo_anim_ctrl_if.sv
// Game-logic / VGA side bundle for the Kyo animation controller.
// The master side drives requests, position and draw coordinates. The slave side returns ROM addressing.
interface kyo_anim_ctrl_if #(
    parameter int ADDR_W = kyo_sprite_pkg::ADDR_W
);

    logic              frame_start;
    logic              kick_req;
    logic              kick_ack;
    logic              busy;
    logic [9:0]        pos_x;
    logic [9:0]        pos_y;
    logic              facing_left;
    logic [9:0]        draw_x;
    logic [9:0]        draw_y;
    logic [ADDR_W-1:0] rom_address;
    logic              sprite_on;
    logic [2:0]        frame_idx;

    modport master (
        output frame_start, kick_req, pos_x, pos_y, facing_left, draw_x, draw_y,
        input  kick_ack, busy, rom_address, sprite_on, frame_idx
    );

    modport slave (
        input  frame_start, kick_req, pos_x, pos_y, facing_left, draw_x, draw_y,
        output kick_ack, busy, rom_address, sprite_on, frame_idx
    );

endinterface

// File: rtl/kyo_sprite_addr_gen.sv
// Per-pixel sprite window test, horizontal mirroring and the registered ROM
// address / sprite_on stage, one cycle behind draw_x/draw_y.
module kyo_sprite_addr_gen #(
    parameter int SPRITE_W = kyo_sprite_pkg::SPRITE_W,
    parameter int SPRITE_H = kyo_sprite_pkg::SPRITE_H,
    parameter int ADDR_W   = kyo_sprite_pkg::ADDR_W
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [2:0]        disp_frame,
    input  logic [9:0]        lat_x,
    input  logic [9:0]        lat_y,
    input  logic              lat_face,
    input  logic [9:0]        draw_x,
    input  logic [9:0]        draw_y,
    output logic [ADDR_W-1:0] rom_address,
    output logic              sprite_on
);

    localparam int FRAME_WORDS = SPRITE_W * SPRITE_H;

    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic               in_x;
    logic               in_y;
    logic               in_win;
    logic [ADDR_W-1:0]  dx_ext;
    logic [ADDR_W-1:0]  dy_ext;
    logic [ADDR_W-1:0]  col;
    logic [ADDR_W-1:0]  frame_base;
    logic [ADDR_W-1:0]  row_base;
    logic [ADDR_W-1:0]  next_addr;

    // A pixel left of or above the sprite gives a negative offset. The sign bit rejects it before the magnitude compare.
    assign dx = $signed({1'b0, draw_x}) - $signed({1'b0, lat_x});
    assign dy = $signed({1'b0, draw_y}) - $signed({1'b0, lat_y});

    assign dx_ext = ADDR_W'(dx[9:0]);
    assign dy_ext = ADDR_W'(dy[9:0]);

    assign in_x   = !dx[10] && (dx_ext < ADDR_W'(SPRITE_W));
    assign in_y   = !dy[10] && (dy_ext < ADDR_W'(SPRITE_H));
    assign in_win = in_x && in_y;

    assign col        = lat_face ? (ADDR_W'(SPRITE_W - 1) - dx_ext) : dx_ext;
    assign frame_base = ADDR_W'(disp_frame) * ADDR_W'(FRAME_WORDS);
    assign row_base   = dy_ext * ADDR_W'(SPRITE_W);
    assign next_addr  = frame_base + row_base + col;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            rom_address <= '0;
            sprite_on   <= 1'b0;
        end else if (in_win) begin
            rom_address <= next_addr;
            sprite_on   <= 1'b1;
        end else begin
            rom_address <= '0;
            sprite_on   <= 1'b0;
        end
    end

endmodule

// File: rtl/kyo_anim_ctrl.sv
// Kyo animation sequencer: holds the stand pose, plays the kick frames on request,
// and latches frame/position on frame_start so the sprite never tears mid-frame.
module kyo_anim_ctrl #(
    parameter int SPRITE_W        = kyo_sprite_pkg::SPRITE_W,
    parameter int SPRITE_H        = kyo_sprite_pkg::SPRITE_H,
    parameter int NUM_FRAMES      = 4,
    parameter int TICKS_PER_FRAME = 6,
    parameter int ADDR_W          = kyo_sprite_pkg::ADDR_W
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    kyo_anim_ctrl_if.slave   bus
);

    import kyo_sprite_pkg::*;

    localparam int                TICK_W     = cnt_width(TICKS_PER_FRAME);
    localparam logic [TICK_W-1:0] LAST_TICK  = TICK_W'(TICKS_PER_FRAME - 1);
    localparam logic [2:0]        LAST_FRAME = 3'(NUM_FRAMES - 1);

    anim_state_t       state;
    logic [TICK_W-1:0] tick;
    logic [2:0]        frame_idx;
    logic              kick_ack;
    logic              busy;

    logic [2:0]        disp_frame;
    logic [9:0]        lat_x;
    logic [9:0]        lat_y;
    logic              lat_face;

    // NOTE: all sequential state uses non-blocking assignments, so each branch sees the pre-edge values of tick and frame_idx.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            tick      <= '0;
            frame_idx <= '0;
            kick_ack  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            kick_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.kick_req) begin
                        state     <= KICK;
                        kick_ack  <= 1'b1;
                        busy      <= 1'b1;
                        frame_idx <= 3'd1;
                        tick      <= '0;
                    end
                end
                KICK: begin
                    if (bus.frame_start) begin
                        if (tick == LAST_TICK) begin
                            tick <= '0;
                            if (frame_idx == LAST_FRAME) begin
                                state     <= IDLE;
                                frame_idx <= '0;
                                busy      <= 1'b0;
                            end else begin
                                frame_idx <= frame_idx + 3'd1;
                            end
                        end else begin
                            tick <= tick + TICK_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Display-side copies move only at vertical blank. They take the sequencer frame as it stood before this edge.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_frame <= '0;
            lat_x      <= '0;
            lat_y      <= '0;
            lat_face   <= 1'b0;
        end else if (bus.frame_start) begin
            disp_frame <= frame_idx;
            lat_x      <= bus.pos_x;
            lat_y      <= bus.pos_y;
            lat_face   <= bus.facing_left;
        end
    end

    kyo_sprite_addr_gen #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .ADDR_W   (ADDR_W)
    ) u_addr_gen (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .disp_frame  (disp_frame),
        .lat_x       (lat_x),
        .lat_y       (lat_y),
        .lat_face    (lat_face),
        .draw_x      (bus.draw_x),
        .draw_y      (bus.draw_y),
        .rom_address (bus.rom_address),
        .sprite_on   (bus.sprite_on)
    );

    assign bus.kick_ack  = kick_ack;
    assign bus.busy      = busy;
    assign bus.frame_idx = frame_idx;

endmodule

// File: tb/tb_kyo_anim_ctrl.sv
// Self-checking bench for kyo_anim_ctrl. A frame-count model of the kick predicts every output each cycle.
// Directed literal checks pin the model to hand-computed values.
module tb_kyo_anim_ctrl;

    localparam int W  = 64;
    localparam int H  = 96;
    localparam int NF = 4;
    localparam int T  = 6;
    localparam int AW = 17;

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;

    kyo_anim_ctrl_if #(.ADDR_W(AW)) bus ();

    kyo_anim_ctrl #(
        .SPRITE_W        (W),
        .SPRITE_H        (H),
        .NUM_FRAMES      (NF),
        .TICKS_PER_FRAME (T),
        .ADDR_W          (AW)
    ) dut (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 vga_clk = ~vga_clk;

    int total = 0;
    int bad   = 0;
    int ack_count = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // The model counts frame_start pulses since acceptance; the shown frame is 1 + count/T.
    bit m_kick = 1'b0;
    int m_fs = 0;
    int m_disp = 0, m_lx = 0, m_ly = 0;
    bit m_face = 1'b0;
    int m_dx, m_dy, m_col;
    int e_addr = 0, e_fidx = 0;
    bit e_on = 1'b0, e_ack = 1'b0, e_busy = 1'b0;

    function automatic int cur_frame(input bit kick, input int fs);
        return kick ? 1 + fs / T : 0;
    endfunction

    always @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            m_kick = 0; m_fs = 0; m_disp = 0; m_lx = 0; m_ly = 0; m_face = 0;
            e_addr = 0; e_on = 0; e_ack = 0; e_busy = 0; e_fidx = 0;
        end else begin
            m_dx = int'(bus.draw_x) - m_lx;
            m_dy = int'(bus.draw_y) - m_ly;
            if (m_dx >= 0 && m_dx < W && m_dy >= 0 && m_dy < H) begin
                m_col  = m_face ? (W - 1 - m_dx) : m_dx;
                e_addr = m_disp * W * H + m_dy * W + m_col;
                e_on   = 1;
            end else begin
                e_addr = 0;
                e_on   = 0;
            end
            if (bus.frame_start) begin
                m_disp = cur_frame(m_kick, m_fs);
                m_lx   = int'(bus.pos_x);
                m_ly   = int'(bus.pos_y);
                m_face = bus.facing_left;
            end
            e_ack = 0;
            if (!m_kick) begin
                if (bus.kick_req) begin
                    m_kick = 1;
                    m_fs   = 0;
                    e_ack  = 1;
                end
            end else if (bus.frame_start) begin
                m_fs++;
                if (m_fs == (NF - 1) * T) m_kick = 0;
            end
            e_busy = m_kick;
            e_fidx = cur_frame(m_kick, m_fs);
        end
    end

    always @(negedge vga_clk) begin
        if (cmp_en) begin
            check("cyc_rom_address", 32'(bus.rom_address), 32'(e_addr));
            check("cyc_sprite_on",   32'(bus.sprite_on),   32'(e_on));
            check("cyc_kick_ack",    32'(bus.kick_ack),    32'(e_ack));
            check("cyc_busy",        32'(bus.busy),        32'(e_busy));
            check("cyc_frame_idx",   32'(bus.frame_idx),   32'(e_fidx));
        end
        if (bus.kick_ack === 1'b1) ack_count++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge vga_clk);
    endtask

    task automatic fs_pulse();
        bus.frame_start = 1'b1;
        @(negedge vga_clk);
        bus.frame_start = 1'b0;
    endtask

    // Each pulse is followed by one settle cycle so the address already reflects the new latch.
    task automatic fs_n(input int n);
        repeat (n) begin
            fs_pulse();
            cyc(1);
        end
    endtask

    task automatic set_draw(input int x, input int y);
        bus.draw_x = 10'(x);
        bus.draw_y = 10'(y);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    initial begin
        bus.frame_start = 1'b0;
        bus.kick_req    = 1'b0;
        bus.pos_x       = '0;
        bus.pos_y       = '0;
        bus.facing_left = 1'b0;
        set_draw(0, 0);

        #1;
        check("rst_rom_address", 32'(bus.rom_address), 32'd0);
        check("rst_sprite_on",   32'(bus.sprite_on),   32'd0);
        check("rst_busy",        32'(bus.busy),        32'd0);
        check("rst_kick_ack",    32'(bus.kick_ack),    32'd0);
        check("rst_frame_idx",   32'(bus.frame_idx),   32'd0);
        cyc(3);
        reset_n = 1'b1;
        cmp_en  = 1'b1;
        cyc(2);

        // Stand pose addressing.
        bus.pos_x = 10'd100;
        bus.pos_y = 10'd200;
        fs_pulse();
        set_draw(110, 205);
        cyc(1);
        check("stand_addr", 32'(bus.rom_address), 32'd330);
        check("stand_on",   32'(bus.sprite_on),   32'd1);
        set_draw(164, 205);
        cyc(1);
        check("right_edge_on",   32'(bus.sprite_on),   32'd0);
        check("right_edge_addr", 32'(bus.rom_address), 32'd0);
        set_draw(99, 205);
        cyc(1);
        check("left_edge_on",   32'(bus.sprite_on),   32'd0);
        check("left_edge_addr", 32'(bus.rom_address), 32'd0);

        // Mirrored stand pose.
        bus.facing_left = 1'b1;
        fs_pulse();
        set_draw(110, 205);
        cyc(1);
        check("mirror_addr", 32'(bus.rom_address), 32'd373);
        bus.facing_left = 1'b0;
        fs_n(1);

        // Full kick.
        set_draw(100, 200);
        bus.kick_req = 1'b1;
        cyc(1);
        bus.kick_req = 1'b0;
        check("kick_ack_pulse", 32'(bus.kick_ack),  32'd1);
        check("kick_busy",      32'(bus.busy),      32'd1);
        check("kick_frame1",    32'(bus.frame_idx), 32'd1);
        cyc(1);
        check("kick_ack_single", 32'(bus.kick_ack), 32'd0);
        fs_n(1);
        check("kick_fs1_addr", 32'(bus.rom_address), 32'd6144);
        fs_n(5);
        fs_n(1);
        check("kick_fs7_addr", 32'(bus.rom_address), 32'd12288);
        fs_n(5);
        fs_n(1);
        check("kick_fs13_addr", 32'(bus.rom_address), 32'd18432);
        fs_n(4);
        check("kick_fs17_busy",  32'(bus.busy),      32'd1);
        check("kick_fs17_frame", 32'(bus.frame_idx), 32'd3);
        fs_n(1);
        check("kick_fs18_busy",  32'(bus.busy),        32'd0);
        check("kick_fs18_frame", 32'(bus.frame_idx),   32'd0);
        check("kick_fs18_addr",  32'(bus.rom_address), 32'd18432);
        fs_n(1);
        check("kick_fs19_addr", 32'(bus.rom_address), 32'd0);
        check("kick_fs19_on",   32'(bus.sprite_on),   32'd1);

        // Request held through the whole kick.
        ack_count = 0;
        bus.kick_req = 1'b1;
        cyc(1);
        check("held_first_ack", 32'(bus.kick_ack), 32'd1);
        fs_n(6);
        check("held_cadence_frame", 32'(bus.frame_idx), 32'd2);
        fs_n(11);
        #1;
        check("held_ack_count_mid", 32'(ack_count), 32'd1);
        check("held_busy_mid",      32'(bus.busy),  32'd1);
        fs_pulse();
        check("held_exit_busy", 32'(bus.busy),     32'd0);
        check("held_exit_ack",  32'(bus.kick_ack), 32'd0);
        cyc(1);
        #1;
        check("held_reaccept_ack", 32'(bus.kick_ack), 32'd1);
        check("held_reaccept_busy", 32'(bus.busy),    32'd1);
        check("held_ack_count_end", 32'(ack_count),   32'd2);
        bus.kick_req = 1'b0;

        // Reset in the middle of the second kick, checked before any clock edge.
        fs_n(3);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_rom_address", 32'(bus.rom_address), 32'd0);
        check("midrst_sprite_on",   32'(bus.sprite_on),   32'd0);
        check("midrst_busy",        32'(bus.busy),        32'd0);
        check("midrst_kick_ack",    32'(bus.kick_ack),    32'd0);
        check("midrst_frame_idx",   32'(bus.frame_idx),   32'd0);
        cyc(2);
        reset_n = 1'b1;
        cyc(2);

        // Request and frame_start on the same edge in IDLE.
        bus.kick_req    = 1'b1;
        bus.frame_start = 1'b1;
        cyc(1);
        bus.kick_req    = 1'b0;
        bus.frame_start = 1'b0;
        check("simul_ack", 32'(bus.kick_ack), 32'd1);
        cyc(1);
        check("simul_stand_addr", 32'(bus.rom_address), 32'd0);
        check("simul_stand_on",   32'(bus.sprite_on),   32'd1);
        fs_n(1);
        check("simul_next_addr", 32'(bus.rom_address), 32'd6144);

        cyc(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
